// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker over one ASCII character per accepted cycle.
// Latency 1 cycle; no backpressure, characters are consumed whenever in_valid is high.
module block_nest_checker #(
  parameter int DEPTH_W   = 4,
  parameter bit DELIM_ANY = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic               result
);

  typedef enum logic [3:0] {
    S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
  } state_t;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  state_t             state, state_n;
  logic [DEPTH_W-1:0] depth_n;
  logic               error_n;
  // Values before the last keyword's tentative update, restored on revert.
  logic [DEPTH_W-1:0] sav_depth, sav_depth_n;
  logic               sav_error, sav_error_n;

  logic [7:0] lc;
  logic       is_letter;
  logic       is_delim;

  assign lc        = in | 8'h20;
  assign is_letter = ((in >= 8'h41) && (in <= 8'h5A)) || ((in >= 8'h61) && (in <= 8'h7A));
  assign is_delim  = DELIM_ANY ? !is_letter : (in == 8'h20);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      depth     <= '0;
      error     <= 1'b0;
      sav_depth <= '0;
      sav_error <= 1'b0;
    end else begin
      state     <= state_n;
      depth     <= depth_n;
      error     <= error_n;
      sav_depth <= sav_depth_n;
      sav_error <= sav_error_n;
    end
  end

  always_comb begin
    state_n     = state;
    depth_n     = depth;
    error_n     = error;
    sav_depth_n = sav_depth;
    sav_error_n = sav_error;
    if (in_valid) begin
      if (is_delim) begin
        // A delimiter after BEGIN/END commits the tentative update as-is.
        state_n = S_IDLE;
      end else begin
        state_n = S_OTHER;
        case (state)
          S_IDLE: begin
            if (is_letter && lc == 8'h62)      state_n = S_B;
            else if (is_letter && lc == 8'h65) state_n = S_E;
          end
          S_B:    if (is_letter && lc == 8'h65) state_n = S_BE;
          S_BE:   if (is_letter && lc == 8'h67) state_n = S_BEG;
          S_BEG:  if (is_letter && lc == 8'h69) state_n = S_BEGI;
          S_BEGI: begin
            if (is_letter && lc == 8'h6E) begin
              state_n     = S_BEGIN;
              sav_depth_n = depth;
              sav_error_n = error;
              if (depth == DEPTH_MAX) error_n = 1'b1;
              else                    depth_n = depth + 1'b1;
            end
          end
          S_E:    if (is_letter && lc == 8'h6E) state_n = S_EN;
          S_EN: begin
            if (is_letter && lc == 8'h64) begin
              state_n     = S_END;
              sav_depth_n = depth;
              sav_error_n = error;
              if (depth == '0) error_n = 1'b1;
              else             depth_n = depth - 1'b1;
            end
          end
          S_BEGIN, S_END: begin
            // Keyword turned out to be a prefix of a longer word: undo it.
            depth_n = sav_depth;
            error_n = sav_error;
          end
          default: state_n = S_OTHER;
        endcase
      end
    end
  end

  assign result = (depth == '0) && !error;

endmodule

// File: tb/tb_block_nest_checker.sv
// Directed bench for block_nest_checker: three instances (default, DEPTH_W=2, DELIM_ANY=1)
// share one character stream; each task checks the instance relevant to its scenario.
module tb_block_nest_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in;

  logic [3:0] depth;     logic error;     logic result;
  logic [1:0] depth_w2;  logic error_w2;  logic result_w2;
  logic [3:0] depth_any; logic error_any; logic result_any;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  block_nest_checker #(.DEPTH_W(4), .DELIM_ANY(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .depth(depth), .error(error), .result(result));

  block_nest_checker #(.DEPTH_W(2), .DELIM_ANY(1'b0)) dut_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .depth(depth_w2), .error(error_w2), .result(result_w2));

  block_nest_checker #(.DEPTH_W(4), .DELIM_ANY(1'b1)) dut_any (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .depth(depth_any), .error(error_any), .result(result_any));

  task automatic send_char(input logic [7:0] c);
    in       = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++;
    if (result !== 1'b1) begin errors++; $display("FAIL reset_result: got %b want 1", result); end
    checks++;
    // Reset must win over a valid 'd' completing "end" at depth 0.
    send_str("en");
    reset = 1'b1; in = 8'h64; in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    if (error !== 1'b0) begin errors++; $display("FAIL reset_wins: error got %b want 0", error); end
    checks++;
    send_str("d ");
    if (error !== 1'b0) begin errors++; $display("FAIL reset_fsm_idle: error got %b want 0", error); end
    checks++;
  endtask

  task automatic test_nesting();
    do_reset();
    send_str("a BEgIn");
    if (depth !== 4'd1 || result !== 1'b0) begin
      errors++; $display("FAIL nest_begin: depth %0d result %b want 1 0", depth, result);
    end
    checks++;
    send_str(" End");
    if (depth !== 4'd0 || result !== 1'b1) begin
      errors++; $display("FAIL nest_end_tent: depth %0d result %b want 0 1", depth, result);
    end
    checks++;
    send_str("c");
    if (depth !== 4'd1 || result !== 1'b0) begin
      errors++; $display("FAIL nest_revert: depth %0d result %b want 1 0", depth, result);
    end
    checks++;
    send_str(" end");
    if (result !== 1'b1) begin errors++; $display("FAIL nest_end: result %b want 1", result); end
    checks++;
    send_str(" BEgIn");
    if (depth !== 4'd1 || result !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL nest_final: depth %0d result %b error %b want 1 0 0", depth, result, error);
    end
    checks++;
  endtask

  task automatic test_underflow();
    do_reset();
    send_str("end");
    if (error !== 1'b1 || depth !== 4'd0) begin
      errors++; $display("FAIL under_tent: error %b depth %0d want 1 0", error, depth);
    end
    checks++;
    send_str(" ");
    if (error !== 1'b1 || result !== 1'b0) begin
      errors++; $display("FAIL under_commit: error %b result %b want 1 0", error, result);
    end
    checks++;
    send_str("begin end ");
    if (error !== 1'b1 || depth !== 4'd0 || result !== 1'b0) begin
      errors++; $display("FAIL under_sticky: error %b depth %0d result %b want 1 0 0", error, depth, result);
    end
    checks++;
  endtask

  task automatic test_underflow_revert();
    do_reset();
    send_str("end");
    if (error !== 1'b1) begin errors++; $display("FAIL urev_tent: error %b want 1", error); end
    checks++;
    send_str("x");
    if (error !== 1'b0 || result !== 1'b1) begin
      errors++; $display("FAIL urev_undo: error %b result %b want 0 1", error, result);
    end
    checks++;
    send_str(" ");
    if (result !== 1'b1) begin errors++; $display("FAIL urev_after: result %b want 1", result); end
    checks++;
  endtask

  task automatic test_overflow();
    logic [1:0] exp_d [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       exp_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_str("begin ");
      if (depth_w2 !== exp_d[i] || error_w2 !== exp_e[i]) begin
        errors++;
        $display("FAIL overflow_%0d: depth %0d error %b want %0d %b", i, depth_w2, error_w2, exp_d[i], exp_e[i]);
      end
      checks++;
    end
  endtask

  task automatic test_valid_gap();
    do_reset();
    send_str("beg");
    in = 8'h78;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      if (depth !== 4'd0 || error !== 1'b0) begin
        errors++; $display("FAIL gap_idle_%0d: depth %0d error %b want 0 0", i, depth, error);
      end
      checks++;
    end
    send_str("in ");
    if (depth !== 4'd1) begin errors++; $display("FAIL gap_resume: depth %0d want 1", depth); end
    checks++;
  endtask

  task automatic test_delim();
    do_reset();
    send_str("begin");
    if (depth !== 4'd1 || depth_any !== 4'd1) begin
      errors++; $display("FAIL delim_tent: depth %0d any %0d want 1 1", depth, depth_any);
    end
    checks++;
    send_str(";");
    if (depth !== 4'd0) begin errors++; $display("FAIL delim_space_only: depth %0d want 0", depth); end
    checks++;
    if (depth_any !== 4'd1) begin errors++; $display("FAIL delim_any: depth %0d want 1", depth_any); end
    checks++;
    send_str("x");
    if (depth_any !== 4'd1) begin errors++; $display("FAIL delim_any_commit: depth %0d want 1", depth_any); end
    checks++;
  endtask

  task automatic test_reset_midword();
    do_reset();
    send_str("begi");
    do_reset();
    send_str("n ");
    if (depth !== 4'd0 || error !== 1'b0) begin
      errors++; $display("FAIL midword_reset: depth %0d error %b want 0 0", depth, error);
    end
    checks++;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in       = 8'h00;
    @(posedge clk); #1;
    test_reset();
    test_nesting();
    test_underflow();
    test_underflow_revert();
    test_overflow();
    test_valid_gap();
    test_delim();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
